// File: rtl/traffic_phase_ctrl_pkg.sv
// traffic_pkg: shared definitions for the intersection phase controller.
//   - phase codes PH_* as exported on the phase output
//   - lamp encodings {red, yellow, green}
//   - TW: phase timer width
//   - state_e: FSM state type whose encoding equals the phase code
package traffic_pkg;

  localparam int TW = 4;

  localparam logic [2:0] PH_MAIN_GREEN = 3'd0;
  localparam logic [2:0] PH_MAIN_YEL   = 3'd1;
  localparam logic [2:0] PH_ALL_RED_A  = 3'd2;
  localparam logic [2:0] PH_SIDE_GREEN = 3'd3;
  localparam logic [2:0] PH_SIDE_YEL   = 3'd4;
  localparam logic [2:0] PH_ALL_RED_B  = 3'd5;
  localparam logic [2:0] PH_NIGHT      = 3'd6;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN = PH_MAIN_GREEN,
    ST_MAIN_YEL   = PH_MAIN_YEL,
    ST_ALL_RED_A  = PH_ALL_RED_A,
    ST_SIDE_GREEN = PH_SIDE_GREEN,
    ST_SIDE_YEL   = PH_SIDE_YEL,
    ST_ALL_RED_B  = PH_ALL_RED_B,
    ST_NIGHT      = PH_NIGHT,
    ST_BAD        = 3'd7
  } state_e;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: sensor/tick inputs and lamp/display outputs.
//   tick, side_req, night : driven by the board (master)
//   main_ryg, side_ryg    : lamp drives {red, yellow, green}
//   phase, remain         : to the 7-segment display block
interface traffic_phase_ctrl_if;
  import traffic_pkg::*;

  logic          tick;
  logic          side_req;
  logic          night;
  logic [2:0]    main_ryg;
  logic [2:0]    side_ryg;
  logic [2:0]    phase;
  logic [TW-1:0] remain;

  modport master (
    output tick, side_req, night,
    input  main_ryg, side_ryg, phase, remain
  );

  modport slave (
    input  tick, side_req, night,
    output main_ryg, side_ryg, phase, remain
  );

endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// phase_timer: loadable down-counter for phase durations.
//   clk, clr (async, active-low), load/load_val (priority), tick (decrement enable)
//   remain: current count; zero: remain == 0
// The counter saturates at zero; leaving a phase is the FSM's decision.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] remain,
  output logic          zero
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (tick && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= RST_VAL;
    else      cnt_q <= cnt_d;
  end

  assign remain = cnt_q;
  assign zero   = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road intersection light controller.
//   clk, clr (async, active-low)
//   bus (slave): tick, side_req, night in; main_ryg, side_ryg, phase, remain out
// Optional night flashing mode is compiled in with TRAFFIC_NIGHT_FLASH_EN.
//
// state          | meaning
// ST_MAIN_GREEN  | main green, extended until a side request is pending
// ST_MAIN_YEL    | main yellow
// ST_ALL_RED_A   | clearance before side green
// ST_SIDE_GREEN  | side green
// ST_SIDE_YEL    | side yellow
// ST_ALL_RED_B   | clearance before main green
// ST_NIGHT       | both yellows flashing (optional mode only)
// ST_BAD         | illegal code, recovers to ST_MAIN_GREEN
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN_MIN = 12,
  parameter int unsigned T_SIDE     = 8,
  parameter int unsigned T_YEL      = 3,
  parameter int unsigned T_RED      = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  traffic_phase_ctrl_if.slave  bus
);

  localparam logic [TW-1:0] D_MAIN = TW'(T_MAIN_MIN - 1);
  localparam logic [TW-1:0] D_SIDE = TW'(T_SIDE - 1);
  localparam logic [TW-1:0] D_YEL  = TW'(T_YEL - 1);
  localparam logic [TW-1:0] D_RED  = TW'(T_RED - 1);

  state_e        state_q, state_d;
  logic [1:0]    side_sync_q;
  logic          side_s;
  logic          pending_q, pending_d;
  logic          load;
  logic [TW-1:0] load_val;
  logic [TW-1:0] remain;
  logic          zero;
  logic          tick;

  assign tick   = bus.tick;
  assign side_s = side_sync_q[1];

  function automatic logic [TW-1:0] dur_m1(input state_e s);
    case (s)
      ST_MAIN_GREEN: return D_MAIN;
      ST_MAIN_YEL,
      ST_SIDE_YEL:   return D_YEL;
      ST_ALL_RED_A,
      ST_ALL_RED_B:  return D_RED;
      ST_SIDE_GREEN: return D_SIDE;
      default:       return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) side_sync_q <= 2'b00;
    else      side_sync_q <= {side_sync_q[0], bus.side_req};
  end

`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic [1:0] night_sync_q;
  logic       night_s;
  logic       flash_q, flash_d;

  assign night_s = night_sync_q[1];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) night_sync_q <= 2'b00;
    else      night_sync_q <= {night_sync_q[0], bus.night};
  end
`else
  logic unused_night;
  assign unused_night = bus.night;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_GREEN: if (tick && zero && (pending_q || side_s)) state_d = ST_MAIN_YEL;
      ST_MAIN_YEL:   if (tick && zero) state_d = ST_ALL_RED_A;
      ST_ALL_RED_A:  if (tick && zero) state_d = ST_SIDE_GREEN;
      ST_SIDE_GREEN: if (tick && zero) state_d = ST_SIDE_YEL;
      ST_SIDE_YEL:   if (tick && zero) state_d = ST_ALL_RED_B;
      ST_ALL_RED_B:  if (tick && zero) state_d = ST_MAIN_GREEN;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_NIGHT:      if (tick && !night_s) state_d = ST_ALL_RED_B;
`endif
      default:       state_d = ST_MAIN_GREEN;
    endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night overrides any running phase timer.
    if (tick && night_s && (state_q != ST_NIGHT)) state_d = ST_NIGHT;
`endif
    // Every phase change reloads the timer; the load wins over the same tick.
    load     = (state_d != state_q);
    load_val = dur_m1(state_d);
  end

  always_comb begin
    pending_d = pending_q;
    if (side_s && (state_q inside {ST_MAIN_GREEN, ST_MAIN_YEL, ST_ALL_RED_A,
                                   ST_SIDE_YEL, ST_ALL_RED_B}))
      pending_d = 1'b1;
    if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN))
      pending_d = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (state_d == ST_NIGHT)
      pending_d = 1'b0;
`endif
  end

`ifdef TRAFFIC_NIGHT_FLASH_EN
  always_comb begin
    flash_d = flash_q;
    if ((state_d == ST_NIGHT) && (state_q != ST_NIGHT))
      flash_d = 1'b1;
    else if ((state_q == ST_NIGHT) && tick)
      flash_d = ~flash_q;
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_MAIN_GREEN;
      pending_q <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q   <= flash_d;
`endif
    end
  end

  phase_timer #(.RST_VAL(D_MAIN)) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .remain   (remain),
    .zero     (zero)
  );

  always_comb begin
    bus.main_ryg = LAMP_RED;
    bus.side_ryg = LAMP_RED;
    case (state_q)
      ST_MAIN_GREEN: bus.main_ryg = LAMP_GRN;
      ST_MAIN_YEL:   bus.main_ryg = LAMP_YEL;
      ST_SIDE_GREEN: bus.side_ryg = LAMP_GRN;
      ST_SIDE_YEL:   bus.side_ryg = LAMP_YEL;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_NIGHT: begin
        bus.main_ryg = flash_q ? LAMP_YEL : LAMP_OFF;
        bus.side_ryg = flash_q ? LAMP_YEL : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign bus.phase  = state_q;
  assign bus.remain = remain;

endmodule
